// File: rtl/tri_raster_unit_pkg.sv
// Shared types for the triangle rasteriser: FSM states, edge-width derivation
// and per-edge coefficient record.
package rast_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SCAN,
        ST_DONE
    } rast_state_e;

    function automatic int edge_width(input int coord_w);
        return 2 * coord_w + 4;
    endfunction

    localparam int RAST_COORD_W = 16;
    localparam int COEF_W       = edge_width(RAST_COORD_W);

    typedef struct packed {
        logic signed [COEF_W-1:0] A;
        logic signed [COEF_W-1:0] B;
        logic signed [COEF_W-1:0] C;
    } edge_coef_t;

endpackage

// File: rtl/tri_raster_unit_if.sv
// Triangle-in / fragment-out bus of the rasteriser; slave = rasteriser side.
interface tri_raster_unit_if #(
    parameter int COORD_W  = 16,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
);
    import rast_pkg::*;

    localparam int XW     = $clog2(SCREEN_W);
    localparam int YW     = $clog2(SCREEN_H);
    localparam int EDGE_W = edge_width(COORD_W);

    logic                      tri_valid;
    logic                      tri_ready;
    logic signed [COORD_W-1:0] vx [3];
    logic signed [COORD_W-1:0] vy [3];
    logic                      frag_valid;
    logic                      frag_ready;
    logic [XW-1:0]             frag_x;
    logic [YW-1:0]             frag_y;
    logic signed [EDGE_W-1:0]  frag_w [3];
    logic                      tri_done;
    logic [31:0]               tri_cycles;

    modport slave (
        input  tri_valid, vx, vy, frag_ready,
        output tri_ready, frag_valid, frag_x, frag_y, frag_w, tri_done, tri_cycles
    );

    modport master (
        output tri_valid, vx, vy, frag_ready,
        input  tri_ready, frag_valid, frag_x, frag_y, frag_w, tri_done, tri_cycles
    );

endinterface

// File: rtl/tri_raster_unit_edge_eval.sv
// Incremental edge-function evaluator: keeps the row-start and current value
// and steps them by A (along x) or B (to the next row).
module rast_edge_eval
    import rast_pkg::*;
#(
    parameter int EDGE_W = 36
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_load,
    input  logic                     i_step_x,
    input  logic                     i_step_row,
    input  logic signed [EDGE_W-1:0] i_init,
    input  logic signed [EDGE_W-1:0] i_a,
    input  logic signed [EDGE_W-1:0] i_b,
    output logic signed [EDGE_W-1:0] o_e,
    output logic                     o_neg
);

    logic signed [EDGE_W-1:0] r_a;
    logic signed [EDGE_W-1:0] r_b;
    logic signed [EDGE_W-1:0] r_row;
    logic signed [EDGE_W-1:0] r_cur;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_row <= '0;
            r_cur <= '0;
        end else if (i_load) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_row <= i_init;
            r_cur <= i_init;
        end else if (i_step_row) begin
            r_row <= r_row + r_b;
            r_cur <= r_row + r_b;
        end else if (i_step_x) begin
            r_cur <= r_cur + r_a;
        end
    end

    assign o_e   = r_cur;
    assign o_neg = r_cur[EDGE_W-1];

endmodule

// File: rtl/tri_raster_unit.sv
// Bounding-box triangle rasteriser with edge functions and a per-triangle
// cycle counter. Define RAST_CULL_EN to drop clockwise (area<0) triangles.
module tri_raster_unit
    import rast_pkg::*;
#(
    parameter int COORD_W  = RAST_COORD_W,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    tri_raster_unit_if.slave bus
);

    localparam int XW     = $clog2(SCREEN_W);
    localparam int YW     = $clog2(SCREEN_H);
    localparam int EDGE_W = edge_width(COORD_W);
    localparam logic signed [COORD_W-1:0] XLIM = COORD_W'(SCREEN_W - 1);
    localparam logic signed [COORD_W-1:0] YLIM = COORD_W'(SCREEN_H - 1);
`ifdef RAST_CULL_EN
    localparam bit CULL_EN = 1'b1;
`else
    localparam bit CULL_EN = 1'b0;
`endif

    rast_state_e               r_state, w_next;
    logic signed [COORD_W-1:0] r_vx [3];
    logic signed [COORD_W-1:0] r_vy [3];
    logic [XW-1:0]             r_xmin, r_xmax, r_x;
    logic [YW-1:0]             r_ymin, r_ymax, r_y;
    logic                      r_area_neg;
    logic [31:0]               r_cnt, r_cycles;

    edge_coef_t                w_coef [3];
    logic signed [COEF_W-1:0]  w_init [3];
    logic signed [COEF_W-1:0]  w_area;
    logic signed [COORD_W-1:0] w_xlo, w_xhi, w_ylo, w_yhi;
    logic [XW-1:0]             w_xmin, w_xmax;
    logic [YW-1:0]             w_ymin, w_ymax;
    logic                      w_empty, w_skip;
    logic signed [EDGE_W-1:0]  w_e [3];
    logic [2:0]                w_neg, w_nonpos;
    logic                      w_inside, w_last;
    logic                      w_tri_ready, w_frag_valid, w_done;
    logic                      w_load, w_step_x, w_step_row;

    // Setup arithmetic: edge coefficients, area and the clamped bounding box.
    always_comb begin
        w_area = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            int unsigned ia, ib;
            ia = (i + 1) % 3;
            ib = (i + 2) % 3;
            w_coef[i].A = COEF_W'(r_vy[ia]) - COEF_W'(r_vy[ib]);
            w_coef[i].B = COEF_W'(r_vx[ib]) - COEF_W'(r_vx[ia]);
            w_coef[i].C = COEF_W'(r_vx[ia]) * COEF_W'(r_vy[ib])
                        - COEF_W'(r_vx[ib]) * COEF_W'(r_vy[ia]);
            w_area      = w_area + w_coef[i].C;
        end
        w_xlo = r_vx[0]; w_xhi = r_vx[0];
        w_ylo = r_vy[0]; w_yhi = r_vy[0];
        for (int unsigned i = 1; i < 3; i++) begin
            if (r_vx[i] < w_xlo) w_xlo = r_vx[i];
            if (r_vx[i] > w_xhi) w_xhi = r_vx[i];
            if (r_vy[i] < w_ylo) w_ylo = r_vy[i];
            if (r_vy[i] > w_yhi) w_yhi = r_vy[i];
        end
        w_empty = w_xhi[COORD_W-1] || (w_xlo > XLIM) || w_yhi[COORD_W-1] || (w_ylo > YLIM);
        w_xmin  = w_xlo[COORD_W-1] ? '0 : XW'(w_xlo);
        w_ymin  = w_ylo[COORD_W-1] ? '0 : YW'(w_ylo);
        w_xmax  = (w_xhi > XLIM) ? XW'(SCREEN_W - 1) : XW'(w_xhi);
        w_ymax  = (w_yhi > YLIM) ? YW'(SCREEN_H - 1) : YW'(w_yhi);
        for (int unsigned i = 0; i < 3; i++) begin
            w_init[i] = w_coef[i].A * $signed(COEF_W'(w_xmin))
                      + w_coef[i].B * $signed(COEF_W'(w_ymin)) + w_coef[i].C;
        end
        w_skip = (w_area == '0) || w_empty || (CULL_EN && w_area[COEF_W-1]);
    end

    for (genvar g = 0; g < 3; g++) begin : g_edge
        rast_edge_eval #(.EDGE_W(EDGE_W)) u_edge (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_load     (w_load),
            .i_step_x   (w_step_x),
            .i_step_row (w_step_row),
            .i_init     (w_init[g]),
            .i_a        (w_coef[g].A),
            .i_b        (w_coef[g].B),
            .o_e        (w_e[g]),
            .o_neg      (w_neg[g])
        );
        assign w_nonpos[g]   = w_neg[g] || (w_e[g] == '0);
        assign bus.frag_w[g] = w_e[g];
    end

    assign w_inside = r_area_neg ? (&w_nonpos) : ~(|w_neg);
    assign w_last   = (r_x == r_xmax) && (r_y == r_ymax);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_tri_ready  = 1'b0;
        w_frag_valid = 1'b0;
        w_done       = 1'b0;
        w_load       = 1'b0;
        w_step_x     = 1'b0;
        w_step_row   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tri_ready = 1'b1;
                if (bus.tri_valid) w_next = ST_SETUP;
            end
            ST_SETUP: begin
                w_load = 1'b1;
                w_next = w_skip ? ST_DONE : ST_SCAN;
            end
            ST_SCAN: begin
                w_frag_valid = w_inside;
                if (!w_inside || bus.frag_ready) begin
                    if (w_last)              w_next     = ST_DONE;
                    else if (r_x == r_xmax)  w_step_row = 1'b1;
                    else                     w_step_x   = 1'b1;
                end
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < 3; i++) begin
                r_vx[i] <= '0;
                r_vy[i] <= '0;
            end
            r_xmin     <= '0;
            r_xmax     <= '0;
            r_x        <= '0;
            r_ymin     <= '0;
            r_ymax     <= '0;
            r_y        <= '0;
            r_area_neg <= 1'b0;
            r_cnt      <= '0;
            r_cycles   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (bus.tri_valid) begin
                    for (int unsigned i = 0; i < 3; i++) begin
                        r_vx[i] <= bus.vx[i];
                        r_vy[i] <= bus.vy[i];
                    end
                    r_cnt <= '0;
                end
                ST_SETUP: begin
                    r_xmin     <= w_xmin;
                    r_xmax     <= w_xmax;
                    r_ymin     <= w_ymin;
                    r_ymax     <= w_ymax;
                    r_x        <= w_xmin;
                    r_y        <= w_ymin;
                    r_area_neg <= w_area[COEF_W-1];
                    // A scanned triangle also accounts the setup-to-first-pixel hand-over.
                    r_cnt      <= r_cnt + (w_skip ? 32'd1 : 32'd2);
                end
                ST_SCAN: begin
                    r_cnt <= r_cnt + 32'd1;
                    if (w_step_row) begin
                        r_x <= r_xmin;
                        r_y <= r_y + 1'b1;
                    end else if (w_step_x) begin
                        r_x <= r_x + 1'b1;
                    end
                end
                ST_DONE: r_cycles <= r_cnt + 32'd1;
                default: ;
            endcase
        end
    end

    assign bus.tri_ready  = w_tri_ready;
    assign bus.frag_valid = w_frag_valid;
    assign bus.frag_x     = r_x;
    assign bus.frag_y     = r_y;
    assign bus.tri_done   = w_done;
    assign bus.tri_cycles = r_cycles;

endmodule

// File: tb/tb_tri_raster_unit.sv
// Directed self-checking bench for tri_raster_unit (honours RAST_CULL_EN).
module tb_tri_raster_unit;
    import rast_pkg::*;

    localparam int COORD_W = 16;
    localparam int SW      = 640;
    localparam int SH      = 480;

    typedef struct {
        int     x;
        int     y;
        longint w0;
        longint w1;
        longint w2;
    } frag_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    frag_t exp_q[$];
    frag_t got_q[$];

    always #5 clk = ~clk;

    tri_raster_unit_if #(.COORD_W(COORD_W), .SCREEN_W(SW), .SCREEN_H(SH)) bus ();

    tri_raster_unit #(.COORD_W(COORD_W), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    task automatic check_eq(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Fragments x+y<=4 in raster order, weights Ei = ci + axi*x + byi*y.
    task automatic build_exp(input longint c0, input longint ax0, input longint by0,
                             input longint c1, input longint ax1, input longint by1,
                             input longint c2, input longint ax2, input longint by2);
        exp_q.delete();
        for (int y = 0; y <= 4; y++)
            for (int x = 0; x <= 4 - y; x++)
                exp_q.push_back('{x, y, c0 + ax0*x + by0*y, c1 + ax1*x + by1*y, c2 + ax2*x + by2*y});
    endtask

    task automatic start_tri(input int x0, input int y0, input int x1, input int y1,
                             input int x2, input int y2);
        @(negedge clk);
        bus.vx[0] = COORD_W'(x0); bus.vy[0] = COORD_W'(y0);
        bus.vx[1] = COORD_W'(x1); bus.vy[1] = COORD_W'(y1);
        bus.vx[2] = COORD_W'(x2); bus.vy[2] = COORD_W'(y2);
        bus.tri_valid = 1'b1;
        @(posedge clk);
        #1 bus.tri_valid = 1'b0;
    endtask

    task automatic run_tri(input string name, input int x0, input int y0, input int x1,
                           input int y1, input int x2, input int y2, input int stall_n,
                           input int exp_cycles, input int exp_done_at);
        int     done_at, first_at, stalls, n;
        longint hw0, hw1, hw2;
        done_at = -1; first_at = -1; stalls = 0;
        hw0 = 0; hw1 = 0; hw2 = 0;
        got_q.delete();
        @(negedge clk);
        check_eq({name, "_ready_idle"}, longint'(bus.tri_ready), 1);
        start_tri(x0, y0, x1, y1, x2, y2);
        for (int c = 1; c <= 200 && done_at < 0; c++) begin
            @(negedge clk);
            if (c == 1) check_eq({name, "_ready_setup"}, longint'(bus.tri_ready), 0);
            bus.frag_ready = 1'b1;
            if (bus.frag_valid) begin
                if (first_at < 0) first_at = c;
                if (stall_n > 0 && bus.frag_x == 1 && bus.frag_y == 0) begin
                    if (stalls == 0) begin
                        hw0 = longint'(bus.frag_w[0]);
                        hw1 = longint'(bus.frag_w[1]);
                        hw2 = longint'(bus.frag_w[2]);
                    end else begin
                        check_eq({name, "_hold_w0"}, longint'(bus.frag_w[0]), hw0);
                        check_eq({name, "_hold_w1"}, longint'(bus.frag_w[1]), hw1);
                        check_eq({name, "_hold_w2"}, longint'(bus.frag_w[2]), hw2);
                    end
                    if (stalls < stall_n) begin
                        stalls++;
                        bus.frag_ready = 1'b0;
                    end
                end
                if (bus.frag_ready)
                    got_q.push_back('{int'(bus.frag_x), int'(bus.frag_y), longint'(bus.frag_w[0]),
                                      longint'(bus.frag_w[1]), longint'(bus.frag_w[2])});
            end
            if (bus.tri_done) done_at = c;
        end
        check_eq({name, "_done_at"}, done_at, exp_done_at);
        @(negedge clk);
        check_eq({name, "_done_pulse"}, longint'(bus.tri_done), 0);
        check_eq({name, "_cycles"}, longint'(bus.tri_cycles), exp_cycles);
        check_eq({name, "_ready_after"}, longint'(bus.tri_ready), 1);
        check_eq({name, "_nfrag"}, got_q.size(), exp_q.size());
        if (exp_q.size() > 0) check_eq({name, "_first_at"}, first_at, 2);
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_x%0d", name, i), got_q[i].x, exp_q[i].x);
            check_eq($sformatf("%s_y%0d", name, i), got_q[i].y, exp_q[i].y);
            check_eq($sformatf("%s_w0_%0d", name, i), got_q[i].w0, exp_q[i].w0);
            check_eq($sformatf("%s_w1_%0d", name, i), got_q[i].w1, exp_q[i].w1);
            check_eq($sformatf("%s_w2_%0d", name, i), got_q[i].w2, exp_q[i].w2);
        end
    endtask

    initial begin
        int ndone;
        bus.tri_valid  = 1'b0;
        bus.frag_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.vx[i] = '0;
            bus.vy[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_tri_ready", longint'(bus.tri_ready), 1);
        check_eq("rst_frag_valid", longint'(bus.frag_valid), 0);
        check_eq("rst_tri_done", longint'(bus.tri_done), 0);
        check_eq("rst_tri_cycles", longint'(bus.tri_cycles), 0);
        check_eq("rst_frag_x", longint'(bus.frag_x), 0);
        check_eq("rst_frag_w0", longint'(bus.frag_w[0]), 0);
        rst_n = 1'b1;

        // CCW right triangle: E0=16-4x-4y, E1=4x, E2=4y over a 5x5 box.
        build_exp(16, -4, -4, 0, 4, 0, 0, 0, 4);
        run_tri("basic", 0, 0, 4, 0, 0, 4, 0, 28, 27);

        // Reversed winding: E0=-4y, E1=-4x, E2=4x+4y-16.
`ifdef RAST_CULL_EN
        exp_q.delete();
        run_tri("rev", 0, 4, 4, 0, 0, 0, 0, 2, 2);
`else
        build_exp(0, 0, -4, 0, -4, 0, -16, 4, 4);
        run_tri("rev", 0, 4, 4, 0, 0, 0, 0, 28, 27);
`endif

        exp_q.delete();
        run_tri("collinear", 0, 0, 2, 2, 4, 4, 0, 2, 2);

        exp_q.delete();
        run_tri("offscreen", -10, -10, -5, -10, -10, -5, 0, 2, 2);

        // Clamped to [0,6]x[0,6] = 49 pixels: E0=32-8x-8y, E1=8x+16, E2=8y+16.
        build_exp(32, -8, -8, 16, 8, 0, 16, 0, 8);
        run_tri("clamp", -2, -2, 6, -2, -2, 6, 0, 52, 51);

        build_exp(16, -4, -4, 0, 4, 0, 0, 0, 4);
        run_tri("stall", 0, 0, 4, 0, 0, 4, 3, 31, 30);

        // Abort in the middle of the scan.
        start_tri(0, 0, 4, 0, 0, 4);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("abort_frag_valid", longint'(bus.frag_valid), 0);
        check_eq("abort_tri_ready", longint'(bus.tri_ready), 1);
        ndone = 0;
        if (bus.tri_done) ndone++;
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (bus.tri_done) ndone++;
        end
        check_eq("abort_no_done", ndone, 0);

        run_tri("after_abort", 0, 0, 4, 0, 0, 4, 0, 28, 27);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
